// File: rtl/adc_channel_filter.sv
// Eight-channel exponential moving average filter with per-channel hysteresis alarms.
// Each sweep runs one channel per clock through a single shared update and compare path.
module adc_channel_filter #(
  parameter int unsigned SHIFT     = 2,
  parameter logic [11:0] HI_THRESH = 12'hC00,
  parameter logic [11:0] LO_THRESH = 12'hA00
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        SAMPLE_TICK,
  input  logic [11:0] CH0,
  input  logic [11:0] CH1,
  input  logic [11:0] CH2,
  input  logic [11:0] CH3,
  input  logic [11:0] CH4,
  input  logic [11:0] CH5,
  input  logic [11:0] CH6,
  input  logic [11:0] CH7,
  output logic [11:0] FILT0,
  output logic [11:0] FILT1,
  output logic [11:0] FILT2,
  output logic [11:0] FILT3,
  output logic [11:0] FILT4,
  output logic [11:0] FILT5,
  output logic [11:0] FILT6,
  output logic [11:0] FILT7,
  output logic [7:0]  ALARM,
  output logic        DONE,
  output logic        BUSY,
  output logic        OVERRUN
);

  localparam int DATA_W = 12;
  localparam int ACC_W  = DATA_W + SHIFT;

  typedef enum logic {IDLE, SCAN} state_t;

  // acc - acc/2^SHIFT + x; bounded by 0xFFF << SHIFT, so it cannot wrap.
  function automatic logic [ACC_W-1:0] ema_step(input logic [ACC_W-1:0] acc,
                                                input logic [DATA_W-1:0] x);
    ema_step = acc - (acc >> SHIFT) + ACC_W'(x);
  endfunction

  function automatic logic [ACC_W-1:0] ema_preload(input logic [DATA_W-1:0] x);
    ema_preload = ACC_W'(x) << SHIFT;
  endfunction

  function automatic logic [DATA_W-1:0] ema_out(input logic [ACC_W-1:0] acc);
    ema_out = acc[ACC_W-1:SHIFT];
  endfunction

  state_t             state_q;
  state_t             state_d;
  logic [2:0]         idx_q;
  logic               primed_q;
  logic [ACC_W-1:0]   acc_q [8];
  logic [7:0]         alarm_q;
  logic               done_q;
  logic               overrun_q;

  logic [DATA_W-1:0]  ch_arr [8];
  logic [DATA_W-1:0]  ch_sel;
  logic [ACC_W-1:0]   acc_sel;
  logic [ACC_W-1:0]   acc_new;
  logic [DATA_W-1:0]  filt_new;
  logic               alarm_new;
  logic               last_ch;

  assign ch_arr  = '{CH0, CH1, CH2, CH3, CH4, CH5, CH6, CH7};
  assign ch_sel  = ch_arr[idx_q];
  assign acc_sel = acc_q[idx_q];
  assign last_ch = (idx_q == 3'd7);

  always_comb begin
    acc_new   = primed_q ? ema_step(acc_sel, ch_sel) : ema_preload(ch_sel);
    filt_new  = ema_out(acc_new);
    alarm_new = alarm_q[idx_q];
    if (filt_new >= HI_THRESH)
      alarm_new = 1'b1;
    else if (filt_new <= LO_THRESH)
      alarm_new = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (SAMPLE_TICK) state_d = SCAN;
      SCAN:    if (last_ch) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sweep sequencing and per-channel state update
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      primed_q  <= 1'b0;
      alarm_q   <= 8'h00;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < 8; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (state_q == IDLE && SAMPLE_TICK)
        idx_q <= 3'd0;
      if (state_q == SCAN) begin
        acc_q[idx_q]   <= acc_new;
        alarm_q[idx_q] <= alarm_new;
        idx_q          <= idx_q + 3'd1;
        if (SAMPLE_TICK)
          overrun_q <= 1'b1;
        if (last_ch) begin
          done_q   <= 1'b1;
          primed_q <= 1'b1;
        end
      end
    end
  end

  assign FILT0   = ema_out(acc_q[0]);
  assign FILT1   = ema_out(acc_q[1]);
  assign FILT2   = ema_out(acc_q[2]);
  assign FILT3   = ema_out(acc_q[3]);
  assign FILT4   = ema_out(acc_q[4]);
  assign FILT5   = ema_out(acc_q[5]);
  assign FILT6   = ema_out(acc_q[6]);
  assign FILT7   = ema_out(acc_q[7]);
  assign ALARM   = alarm_q;
  assign DONE    = done_q;
  assign BUSY    = (state_q == SCAN);
  assign OVERRUN = overrun_q;

endmodule
